// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: N_CH-channel hobby-servo PWM with a shared frame counter and frame-aligned position updates.
// Optional slew limiting of position changes per frame is enabled by defining SERVO_SLEW_EN.
module servo_pwm_multi #(
    parameter int N_CH       = 4,
    parameter int POS_W      = 8,
    parameter int PERIOD_CYC = 1_000_000,
    parameter int MIN_PULSE  = 25_000,
    parameter int STEP_CYC   = 400,
    parameter int SLEW_STEP  = 4,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [POS_W-1:0] wr_pos,
    output logic             wr_err,
    input  logic [N_CH-1:0]  ch_en,
    output logic [N_CH-1:0]  servo,
    output logic             frame_start,
    output logic [N_CH-1:0]  busy
);
    localparam int CNT_W = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam logic [POS_W-1:0] CENTER = POS_W'(2 ** (POS_W - 1));
    localparam logic [CNT_W-1:0] CENTER_W = CNT_W'(MIN_PULSE + (2 ** (POS_W - 1)) * STEP_CYC);

    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        frame_start_q, frame_start_d;
    logic                        wr_ready_q;
    logic                        wr_err_q, wr_err_d;
    logic [N_CH-1:0]             servo_q, servo_d;
    logic [N_CH-1:0]             busy_q, busy_d;
    logic [N_CH-1:0]             ch_en_q, ch_en_d;
    logic [N_CH-1:0][POS_W-1:0]  target_q, target_d;
    logic [N_CH-1:0][POS_W-1:0]  active_q, active_d;
    logic [N_CH-1:0][POS_W-1:0]  next_active;
    logic [N_CH-1:0][CNT_W-1:0]  width_q, width_d;
    logic                        boundary, wr_acc, wr_ok;

`ifdef SERVO_SLEW_EN
    function automatic logic [POS_W-1:0] slew(input logic [POS_W-1:0] t, input logic [POS_W-1:0] a);
        return (int'(t) > int'(a) + SLEW_STEP) ? POS_W'(int'(a) + SLEW_STEP) :
               (int'(t) + SLEW_STEP < int'(a)) ? POS_W'(int'(a) - SLEW_STEP) : t;
    endfunction
`endif

    assign boundary = cnt_q == CNT_W'(PERIOD_CYC - 1);
    assign wr_acc   = wr_valid & wr_ready_q;
    assign wr_ok    = 32'(wr_ch) < N_CH;

    // Positions, enables and widths only move at the boundary so a frame in flight is never altered.
    always_comb begin
        cnt_d         = boundary ? '0 : cnt_q + 1'b1;
        frame_start_d = cnt_q == '0;
        wr_err_d      = wr_acc & ~wr_ok;
        ch_en_d       = boundary ? ch_en : ch_en_q;
        for (int i = 0; i < N_CH; i++) begin
`ifdef SERVO_SLEW_EN
            next_active[i] = slew(target_q[i], active_q[i]);
`else
            next_active[i] = target_q[i];
`endif
            target_d[i] = (wr_acc && wr_ok && int'(wr_ch) == i) ? wr_pos : target_q[i];
            active_d[i] = boundary ? next_active[i] : active_q[i];
            width_d[i]  = boundary ? CNT_W'(MIN_PULSE + int'(next_active[i]) * STEP_CYC) : width_q[i];
            servo_d[i]  = ch_en_q[i] & (cnt_q < width_q[i]);
            busy_d[i]   = active_q[i] != target_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            frame_start_q <= 1'b0;
            wr_ready_q    <= 1'b0;
            wr_err_q      <= 1'b0;
            servo_q       <= '0;
            busy_q        <= '0;
            ch_en_q       <= '0;
            target_q      <= {N_CH{CENTER}};
            active_q      <= {N_CH{CENTER}};
            width_q       <= {N_CH{CENTER_W}};
        end else begin
            cnt_q         <= cnt_d;
            frame_start_q <= frame_start_d;
            wr_ready_q    <= 1'b1;
            wr_err_q      <= wr_err_d;
            servo_q       <= servo_d;
            busy_q        <= busy_d;
            ch_en_q       <= ch_en_d;
            target_q      <= target_d;
            active_q      <= active_d;
            width_q       <= width_d;
        end
    end

    assign wr_ready    = wr_ready_q;
    assign wr_err      = wr_err_q;
    assign servo       = servo_q;
    assign frame_start = frame_start_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_servo_pwm_multi.sv
// tb_servo_pwm_multi: random and directed stimulus against a frame-level reference model of servo_pwm_multi.
module tb_servo_pwm_multi;
    localparam int N = 4, PW = 8, P = 1000, MINP = 100, STEP = 2, SLEW = 4;
`ifdef SERVO_SLEW_EN
    localparam int W_LO = 348, W_HI = 364;
`else
    localparam int W_LO = 100, W_HI = 610;
`endif

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic [1:0] wr_ch = '0;
    logic [7:0] wr_pos = '0;
    logic [3:0] ch_en = '0;
    logic       wr_ready, wr_err, frame_start;
    logic [3:0] servo, busy;

    logic       e_valid = 1'b0;
    logic [2:0] e_ch = '0;
    logic [7:0] e_pos = '0;
    logic       e_ready, e_err, e_fs;
    logic [4:0] e_servo, e_busy;

    always #5 clk = ~clk;

    servo_pwm_multi #(.N_CH(N), .POS_W(PW), .PERIOD_CYC(P), .MIN_PULSE(MINP), .STEP_CYC(STEP), .SLEW_STEP(SLEW)) u_dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ch(wr_ch), .wr_pos(wr_pos),
        .wr_err(wr_err), .ch_en(ch_en), .servo(servo), .frame_start(frame_start), .busy(busy));

    // Five channels widen the channel index to 3 bits, so out-of-range indices become expressible.
    servo_pwm_multi #(.N_CH(5), .POS_W(PW), .PERIOD_CYC(P), .MIN_PULSE(MINP), .STEP_CYC(STEP), .SLEW_STEP(SLEW)) u_err (
        .clk(clk), .rst_n(rst_n), .wr_valid(e_valid), .wr_ready(e_ready), .wr_ch(e_ch), .wr_pos(e_pos),
        .wr_err(e_err), .ch_en(5'h0), .servo(e_servo), .frame_start(e_fs), .busy(e_busy));

    initial if (MINP + (2 ** PW - 1) * STEP >= P) $fatal(1, "illegal timing parameters");

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, got, exp);
        end
    endtask

    function automatic int step_to(input int t, input int a);
`ifdef SERVO_SLEW_EN
        if (t > a + SLEW) return a + SLEW;
        if (t < a - SLEW) return a - SLEW;
`endif
        return t;
    endfunction

    // Model: k counts clock edges since reset release; sample s = k-1 sits at frame position s%P of frame s/P.
    int         k;
    int         tgt[N], act[N], wf[N];
    bit         enf[N];
    logic [3:0] x_servo, x_busy;
    logic       x_fs;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k = 0;
            for (int i = 0; i < N; i++) begin
                tgt[i] = 128; act[i] = 128; wf[i] = MINP + 128 * STEP; enf[i] = 1'b0;
            end
            x_servo = '0; x_busy = '0; x_fs = 1'b0;
        end else begin
            k++;
            for (int i = 0; i < N; i++) begin
                x_servo[i] = enf[i] && ((k - 1) % P < wf[i]);
                x_busy[i]  = act[i] != tgt[i];
            end
            x_fs = (k - 1) % P == 0;
            if (k % P == 0)
                for (int i = 0; i < N; i++) begin
                    act[i] = step_to(tgt[i], act[i]);
                    wf[i]  = MINP + act[i] * STEP;
                    enf[i] = ch_en[i];
                end
            if (wr_valid && k >= 2) tgt[wr_ch] = wr_pos;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_servo", servo, 0);
            chk("rst_busy", busy, 0);
            chk("rst_fs", frame_start, 0);
            chk("rst_ready", wr_ready, 0);
            chk("rst_err", wr_err, 0);
        end else if (k >= 1) begin
            chk("servo", servo, x_servo);
            chk("busy", busy, x_busy);
            chk("frame_start", frame_start, x_fs);
            chk("wr_ready", wr_ready, 1);
            chk("wr_err", wr_err, 0);
        end
    end

    int hc[N];
    int fs_n;

    task automatic wait_phase(input int ph);
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (k % P != ph && g <= 2 * P);
        if (k % P != ph) begin
            n_cmp++; n_bad++;
            $display("FAIL phase_wait: k=%0d phase %0d required %0d", k, k % P, ph);
        end
    endtask

    task automatic measure();
        wait_phase(1);
        fs_n = 0;
        for (int i = 0; i < N; i++) hc[i] = 0;
        repeat (P) begin
            for (int i = 0; i < N; i++) hc[i] += int'(servo[i]);
            fs_n += int'(frame_start);
            @(negedge clk);
        end
    endtask

    task automatic wr(input int ch, input int pos);
        wr_valid = 1'b1; wr_ch = 2'(ch); wr_pos = 8'(pos);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    initial begin
        ch_en = 4'hF;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        chk("ready_pre", wr_ready, 0);
        @(posedge clk);
        #1 chk("ready_rise", wr_ready, 1);
        measure();
        chk("frame0_dark", hc[0], 0);
        measure();
        for (int i = 0; i < N; i++) chk($sformatf("center_w%0d", i), hc[i], 356);
        chk("fs_per_frame", fs_n, 1);

        wait_phase(300);
        wr(1, 0);
        wr(2, 255);
        measure();
        chk("w0_keep", hc[0], 356);
        chk("w1_lo", hc[1], W_LO);
        chk("w2_hi", hc[2], W_HI);
        chk("w3_keep", hc[3], 356);

        wait_phase(998);
        wr(3, 0);
        wr(0, 0);
        measure();
        chk("w3_at998", hc[3], W_LO);
        chk("w0_at999_deferred", hc[0], 356);
        measure();
        chk("w0_at999_applied", hc[0], W_LO);

        @(negedge clk);
        e_valid = 1'b1; e_ch = 3'd5; e_pos = 8'd7;
        @(negedge clk);
        e_valid = 1'b0;
        chk("err_pulse", e_err, 1);
        @(negedge clk);
        chk("err_clear", e_err, 0);
        @(negedge clk);
        chk("err_no_busy", e_busy, 0);
        e_valid = 1'b1; e_ch = 3'd4;
        @(negedge clk);
        e_valid = 1'b0;
        chk("err_valid_ch", e_err, 0);
        @(negedge clk);
        chk("busy_ch4", e_busy, 5'b10000);

        wait_phase(50);
        ch_en[0] = 1'b0;
        measure();
        chk("ch0_disabled", hc[0], 0);
        ch_en = 4'hF;

        for (int c = 0; c < 10 * P; c++) begin
            @(negedge clk);
            wr_valid = $urandom_range(0, 15) == 0;
            wr_ch    = 2'($urandom);
            wr_pos   = ($urandom_range(0, 3) == 0) ? 8'(255 * $urandom_range(0, 1)) : 8'($urandom);
            if ($urandom_range(0, 499) == 0) ch_en = 4'($urandom);
        end
        wr_valid = 1'b0;
        ch_en = 4'hF;
        measure();

        wait_phase(20);
        #2 rst_n = 1'b0;
        #1 chk("async_servo", servo, 0);
        chk("async_busy", busy, 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        chk("ready_pre2", wr_ready, 0);
        @(posedge clk);
        #1 chk("ready_rise2", wr_ready, 1);
        measure();
        measure();
        for (int i = 0; i < N; i++) chk($sformatf("post_rst_w%0d", i), hc[i], 356);

`ifdef SERVO_SLEW_EN
        wr(0, 255);
        for (int j = 1; j <= 32; j++) begin
            measure();
            chk($sformatf("slew_w_f%0d", j), hc[0], 100 + 2 * ((128 + 4 * j < 255) ? 128 + 4 * j : 255));
            chk($sformatf("slew_busy_f%0d", j), busy[0], (j + 1 < 32) ? 1 : 0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/servo_pwm_multi.md
Name: servo_pwm_multi

Overview:
Multi-channel hobby-servo PWM generator. Successor to the single-channel 3-bit-select servo driver: N_CH independent channels, each with a full-resolution position register. A shared frame counter produces the period. Per-channel targets are written through a valid/ready port and applied glitch-free only at frame boundaries, with optional slew limiting. Sits between the control FSM/bus and the servo output pins.

Parameters:
- N_CH, 4, number of servo channels (1..16)
- POS_W, 8, position width; position 0..2^POS_W-1
- PERIOD_CYC, 1_000_000, frame length in clk cycles (20 ms at 50 MHz)
- MIN_PULSE, 25_000, pulse width in cycles at position 0
- STEP_CYC, 400, extra cycles per position LSB
- SLEW_STEP, 4, max position change per frame per channel (used only with SERVO_SLEW_EN)
- Derived, not overridable: CH_W = max(1, $clog2(N_CH)).
- Legality constraint: MIN_PULSE + (2^POS_W-1)*STEP_CYC < PERIOD_CYC. The bench asserts this at elaboration.

Ports:
- clk, in, 1, system clock
- rst_n, in, 1, asynchronous active-low reset
- wr_valid, in, 1, position write request
- wr_ready, out, 1, write accepted when wr_valid & wr_ready
- wr_ch, in, CH_W, target channel index
- wr_pos, in, POS_W, target position
- wr_err, out, 1, 1-cycle pulse: accepted write had wr_ch >= N_CH
- ch_en, in, N_CH, per-channel output enable
- servo, out, N_CH, PWM outputs
- frame_start, out, 1, 1-cycle pulse at start of each frame
- busy, out, N_CH, busy[i] = active position != target position

Interface (already decided): one clock, clk; reset rst_n, asynchronous, active-low.

Behaviour:
- Reset (async assert, sync release) drives:
  - cnt=0; servo=0; frame_start=0; wr_ready=0; wr_err=0; busy=0.
  - target[i] = active[i] = CENTER = 2^(POS_W-1).
  - ch_en_q = 0.
  - wr_ready rises on the first clk edge after rst_n deasserts, then stays 1 (no backpressure).
- Frame counter:
  - cnt counts 0..PERIOD_CYC-1, then wraps to 0.
  - frame_start is registered; it is 1 in the cycle after cnt==0.
- Write:
  - On an accepted write with wr_ch < N_CH, target[wr_ch] <= wr_pos on the next edge.
  - On an accepted write with wr_ch >= N_CH, target is unchanged and wr_err=1 for one cycle.
  - Back-to-back writes are allowed every cycle; the last write to a channel before the boundary wins.
- Frame boundary (cycle where cnt==PERIOD_CYC-1):
  - active[i] <= next_active[i].
  - ch_en_q[i] <= ch_en[i].
  - width[i] <= MIN_PULSE + next_active[i]*STEP_CYC. Computed at full width of cnt with no truncation.
  - A write accepted in this same cycle is not applied until the following boundary.
- Mid-frame changes to target or ch_en never alter the frame in progress. No runt or stretched pulses.
- Output: servo[i] registered: servo[i] <= ch_en_q[i] & (cnt < width[i]).
  - Each enabled channel is high for exactly width[i] cycles per frame.
  - The pulse starts 1 cycle after cnt==0.
- busy[i] is registered; it is updated each cycle from active vs target.
- Reset mid-frame: all outputs go low immediately (async); positions return to CENTER.

Optional Feature:
- Macro: SERVO_SLEW_EN.
- Defined: next_active[i] = target if |target-active| <= SLEW_STEP, else active ± SLEW_STEP toward target. busy[i] stays high until active reaches target.
- Undefined: next_active[i] = target[i], so active jumps in one frame. busy[i] is high only between a write and the next boundary. SLEW_STEP is unused.

Test Plan:
Bench overrides: PERIOD_CYC=1000, MIN_PULSE=100, STEP_CYC=2, N_CH=4, POS_W=8, SLEW_STEP=4.
1. Release reset, ch_en=4'hF, no writes -> all servo high exactly 356 cycles per 1000-cycle frame, in phase. frame_start every 1000 cycles. busy=0.
2. Without SERVO_SLEW_EN: write ch1=0, ch2=255 mid-frame -> current frame unchanged at 356; next frame ch1=100 cycles, ch2=610; ch0/ch3 remain 356.
3. Write at the cnt==999 cycle -> change appears one frame later than a write at cnt==998.
4. Write wr_ch=3'd5 (CH_W widened by bench to 3 for this test) -> wr_err pulses 1 cycle; no target changes.
5. Drop ch_en[0] mid-pulse -> current pulse completes at full width; next frame servo[0] stays 0.
6. With SERVO_SLEW_EN: write ch0=255 from 128 -> width steps 364, 372, ... 610 over 32 frames (last step +3 positions). busy[0] stays high for 32 boundaries, then 0.
7. Assert rst_n low mid-pulse -> servo=0 immediately. After release, targets=128 and wr_ready rises 1 cycle later.
